// File: rtl/cac_frame_controller_if.sv
`timescale 1ns/1ps
// UART byte handshake, settings-RAM register bus and status lines of the frame controller.
// master is the controller side; slave is the UART/RAM side.
interface cac_frame_controller_if #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int ERRCNT_WIDTH = 8
);
   logic [7:0]              rx_data;
   logic                    rx_valid;
   logic [7:0]              tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic [ADDR_WIDTH-1:0]   reg_addr;
   logic [DATA_WIDTH-1:0]   reg_wdata;
   logic                    reg_wr;
   logic                    reg_rd;
   logic [DATA_WIDTH-1:0]   reg_rdata;
   logic                    busy;
   logic [ERRCNT_WIDTH-1:0] err_count;

   modport master (
      input  rx_data, rx_valid, tx_ready, reg_rdata,
      output tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err_count
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, reg_rdata,
      input  tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err_count
   );
endinterface

// File: rtl/cac_frame_controller.sv
`timescale 1ns/1ps
// Framed UART command parser: SYNC/CMD/ADDR/DATA/CHK bytes become register reads and writes,
// answered with ACK+data+checksum or NAK. Protocol errors feed a saturating counter.
module cac_frame_controller #(
   parameter int         ADDR_WIDTH     = 8,
   parameter int         DATA_WIDTH     = 16,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter int         ERRCNT_WIDTH   = 8
) (
   input logic                    clk_cac,
   input logic                    rstb_cac,
   cac_frame_controller_if.master bus
);
   localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
   localparam int DATA_BYTES = (DATA_WIDTH + 7) / 8;
   localparam int TX_W       = DATA_BYTES * 8;
   localparam int TMR_W      = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_RD   = 8'h02;
   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT,
      S_TX_ACK, S_TX_DATA, S_TX_CHK, S_TX_NAK
   } state_t;

   state_t                  state_reg, state_next;
   logic [7:0]              cnt_reg, cnt_next;
   logic [7:0]              chk_reg, chk_next;
   logic                    is_read_reg, is_read_next;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
   logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
   logic [TX_W-1:0]         shift_reg, shift_next;
   logic [7:0]              resp_chk_reg, resp_chk_next;
   logic [7:0]              tx_data_reg, tx_data_next;
   logic                    tx_valid_reg, tx_valid_next;
   logic                    reg_wr_reg, reg_wr_next;
   logic                    reg_rd_reg, reg_rd_next;
   logic                    rd_pending_reg, rd_pending_next;
   logic [ERRCNT_WIDTH-1:0] err_reg, err_next;
   logic [TMR_W-1:0]        timer_reg, timer_next;

   logic                    err_inc;
   logic                    in_frame;
   logic                    timeout_hit;
   logic                    tx_done;
   logic [ADDR_WIDTH+7:0]   addr_shift;
   logic [DATA_WIDTH+7:0]   data_shift;
   logic [TX_W-1:0]         rdata_pad;
   logic [7:0]              rd_bytes [DATA_BYTES];
   logic [7:0]              rdata_xor;

   assign addr_shift  = {addr_reg, bus.rx_data};
   assign data_shift  = {wdata_reg, bus.rx_data};
   assign rdata_pad   = TX_W'(bus.reg_rdata);
   assign in_frame    = (state_reg == S_CMD) || (state_reg == S_ADDR) ||
                        (state_reg == S_DATA) || (state_reg == S_CHK);
   assign timeout_hit = in_frame && !bus.rx_valid && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
   assign tx_done     = tx_valid_reg && bus.tx_ready;

   for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_rd_bytes
      assign rd_bytes[gi] = rdata_pad[gi*8 +: 8];
   end

   always_comb begin
      rdata_xor = 8'h00;
      for (int i = 0; i < DATA_BYTES; i++) begin
         rdata_xor = rdata_xor ^ rd_bytes[i];
      end
   end

   always_ff @(posedge clk_cac or negedge rstb_cac) begin
      if (!rstb_cac) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         chk_reg        <= '0;
         is_read_reg    <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         shift_reg      <= '0;
         resp_chk_reg   <= '0;
         tx_data_reg    <= '0;
         tx_valid_reg   <= 1'b0;
         reg_wr_reg     <= 1'b0;
         reg_rd_reg     <= 1'b0;
         rd_pending_reg <= 1'b0;
         err_reg        <= '0;
         timer_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         chk_reg        <= chk_next;
         is_read_reg    <= is_read_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         shift_reg      <= shift_next;
         resp_chk_reg   <= resp_chk_next;
         tx_data_reg    <= tx_data_next;
         tx_valid_reg   <= tx_valid_next;
         reg_wr_reg     <= reg_wr_next;
         reg_rd_reg     <= reg_rd_next;
         rd_pending_reg <= rd_pending_next;
         err_reg        <= err_next;
         timer_reg      <= timer_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      chk_next        = chk_reg;
      is_read_next    = is_read_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      shift_next      = shift_reg;
      resp_chk_next   = resp_chk_reg;
      reg_wr_next     = 1'b0;
      reg_rd_next     = 1'b0;
      rd_pending_next = reg_rd_reg;
      err_next        = err_reg;
      err_inc         = 1'b0;
      tx_valid_next   = 1'b0;
      tx_data_next    = 8'h00;
      timer_next      = '0;

      if (in_frame && !bus.rx_valid) begin
         timer_next = timer_reg + 1'b1;
      end

      // The registered strobe puts read data on the bus one cycle after RDWAIT.
      if (rd_pending_reg) begin
         shift_next    = rdata_pad;
         resp_chk_next = rdata_xor;
      end

      case (state_reg)
         S_IDLE: begin
            if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
               state_next = S_CMD;
               chk_next   = 8'h00;
               cnt_next   = '0;
            end
         end
         S_CMD: begin
            if (bus.rx_valid) begin
               chk_next = chk_reg ^ bus.rx_data;
               cnt_next = '0;
               if (bus.rx_data == CMD_WR) begin
                  is_read_next = 1'b0;
                  state_next   = S_ADDR;
               end else if (bus.rx_data == CMD_RD) begin
                  is_read_next = 1'b1;
                  state_next   = S_ADDR;
               end else begin
                  err_inc    = 1'b1;
                  state_next = S_TX_NAK;
               end
            end
         end
         S_ADDR: begin
            if (bus.rx_valid) begin
               chk_next  = chk_reg ^ bus.rx_data;
               addr_next = addr_shift[ADDR_WIDTH-1:0];
               if (cnt_reg == 8'(ADDR_BYTES - 1)) begin
                  cnt_next   = '0;
                  state_next = is_read_reg ? S_CHK : S_DATA;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
         end
         S_DATA: begin
            if (bus.rx_valid) begin
               chk_next   = chk_reg ^ bus.rx_data;
               wdata_next = data_shift[DATA_WIDTH-1:0];
               if (cnt_reg == 8'(DATA_BYTES - 1)) begin
                  cnt_next   = '0;
                  state_next = S_CHK;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
         end
         S_CHK: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == chk_reg) begin
                  state_next = S_EXEC;
               end else begin
                  err_inc    = 1'b1;
                  state_next = S_TX_NAK;
               end
            end
         end
         S_EXEC: begin
            if (is_read_reg) begin
               reg_rd_next = 1'b1;
               state_next  = S_RDWAIT;
            end else begin
               reg_wr_next = 1'b1;
               state_next  = S_TX_ACK;
            end
         end
         S_RDWAIT: begin
            resp_chk_next = 8'h00;
            state_next    = S_TX_ACK;
         end
         S_TX_ACK: begin
            if (tx_done) begin
               cnt_next   = '0;
               state_next = is_read_reg ? S_TX_DATA : S_IDLE;
            end
         end
         S_TX_DATA: begin
            if (tx_done) begin
               shift_next = shift_reg << 8;
               if (cnt_reg == 8'(DATA_BYTES - 1)) begin
                  cnt_next   = '0;
                  state_next = S_TX_CHK;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
         end
         S_TX_CHK: begin
            if (tx_done) begin
               state_next = S_IDLE;
            end
         end
         S_TX_NAK: begin
            if (tx_done) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // A silent frame is abandoned without a NAK.
      if (timeout_hit) begin
         err_inc    = 1'b1;
         state_next = S_IDLE;
      end

      if (err_inc && (err_reg != '1)) begin
         err_next = err_reg + 1'b1;
      end

      // The byte on the wire is derived from where the FSM lands, so it is stable while stalled.
      case (state_next)
         S_TX_ACK: begin
            tx_valid_next = 1'b1;
            tx_data_next  = ACK_BYTE;
         end
         S_TX_DATA: begin
            tx_valid_next = 1'b1;
            tx_data_next  = shift_next[TX_W-1 -: 8];
         end
         S_TX_CHK: begin
            tx_valid_next = 1'b1;
            tx_data_next  = resp_chk_next;
         end
         S_TX_NAK: begin
            tx_valid_next = 1'b1;
            tx_data_next  = NAK_BYTE;
         end
         default: begin
            tx_valid_next = 1'b0;
            tx_data_next  = 8'h00;
         end
      endcase
   end

   assign bus.tx_data   = tx_data_reg;
   assign bus.tx_valid  = tx_valid_reg;
   assign bus.reg_addr  = addr_reg;
   assign bus.reg_wdata = wdata_reg;
   assign bus.reg_wr    = reg_wr_reg;
   assign bus.reg_rd    = reg_rd_reg;
   assign bus.busy      = (state_reg != S_IDLE);
   assign bus.err_count = err_reg;
endmodule

// File: doc/cac_frame_controller.md
Name: cac_frame_controller

Overview:
- Parametrised successor to the UART control path inside communication_and_control.
- Parses framed command bytes from a UART receiver into register-bus read/write cycles on the settings memory, then returns ACK/data/NAK bytes to a UART transmitter.
- Generalised in address and data width (multi-byte, big-endian) and adds checksum, inter-byte timeout and a saturating error counter.
- Sits between the UART core and the settings RAM in the clk_f10_p0 domain.

Parameters:
- ADDR_WIDTH, 8: register address width; ADDR_BYTES = ceil(ADDR_WIDTH/8).
- DATA_WIDTH, 16: register data width; DATA_BYTES = ceil(DATA_WIDTH/8).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 100000: maximum clk_cac cycles between received bytes inside a frame.
- ERRCNT_WIDTH, 8: error counter width.

Ports:
- clk_cac in 1: single clock.
- rstb_cac in 1: reset, asynchronous, active-low.
- rx_data in 8: received byte.
- rx_valid in 1: one-cycle strobe, rx_data valid.
- tx_data out 8: byte to transmit.
- tx_valid out 1: tx_data valid; held until tx_ready.
- tx_ready in 1: transmitter accepts byte when tx_valid&tx_ready.
- reg_addr out ADDR_WIDTH: register address.
- reg_wdata out DATA_WIDTH: write data.
- reg_wr out 1: one-cycle write strobe.
- reg_rd out 1: one-cycle read strobe.
- reg_rdata in DATA_WIDTH: read data, valid exactly 1 cycle after reg_rd.
- busy out 1: high in any state other than IDLE.
- err_count out ERRCNT_WIDTH: saturating count of protocol errors.

Behaviour:
- Reset (rstb_cac low, any time, including mid-frame or mid-response): state IDLE. All outputs 0: tx_data, tx_valid, reg_*, busy, err_count. Checksum and timeout counter cleared.
- Frame format: SYNC, CMD, ADDR bytes MSB first, DATA bytes (write only) MSB first, CHK. CHK is the XOR of every byte from CMD up to the byte before CHK. CMD 8'h01 is write; CMD 8'h02 is read.
- States: IDLE, CMD, ADDR, DATA, CHK, EXEC, RDWAIT, TX_ACK, TX_DATA, TX_CHK, TX_NAK.
- IDLE: non-SYNC bytes are dropped silently with no error. SYNC goes to CMD and clears the checksum.
- CMD: 01 or 02 goes to ADDR. Any other value increments err_count and goes to TX_NAK.
- ADDR: shifts ADDR_BYTES bytes into reg_addr (left shift, upper bits truncated to ADDR_WIDTH). Then goes to DATA (write) or CHK (read).
- DATA: shifts DATA_BYTES bytes into reg_wdata in the same way, then goes to CHK.
- CHK: on match, goes to EXEC. On mismatch, err_count increments and the state goes to TX_NAK.
- EXEC (1 cycle): write pulses reg_wr and goes to TX_ACK. Read pulses reg_rd and goes to RDWAIT.
- RDWAIT (1 cycle): captures reg_rdata into the shift register and resets the response checksum.
- Latency: reg_wr/reg_rd is asserted 2 cycles after the CHK byte's rx_valid cycle.
- TX_ACK sends 8'h06. After a write it then goes to IDLE. After a read it goes to TX_DATA, which sends DATA_BYTES bytes MSB first (zero-padded above DATA_WIDTH). TX_CHK then sends the XOR of those data bytes and goes to IDLE.
- TX_NAK sends 8'h15, then goes to IDLE.
- TX handshake: tx_valid is set on entry to a TX state. tx_data stays stable while tx_ready is low. A byte completes on the tx_valid&tx_ready cycle. tx_valid drops for at least 1 cycle between bytes only if the next state is IDLE; consecutive response bytes may be back-to-back.
- rx_valid in any state from EXEC through TX_NAK is ignored. It is not buffered and not counted as an error.
- Timeout: in CMD, ADDR, DATA or CHK, a counter reloads on each rx_valid. Reaching TIMEOUT_CYCLES without a byte increments err_count and returns to IDLE with no NAK.
- err_count saturates at all-ones; it never wraps. An error and a simultaneous saturated counter leave it unchanged.
- A SYNC value received mid-frame is treated as ordinary payload; there is no resynchronisation.

Test Plan:
- Write frame A5 01 10 12 34 37 -> reg_wr pulse with reg_addr=0x10 and reg_wdata=0x1234; tx sends 06; err_count=0; busy returns low after ACK.
- Read frame A5 02 10 12, with reg_rdata=0x1234 one cycle after reg_rd -> tx sends 06 12 34 26 in order.
- Write frame A5 01 10 12 34 00 (bad CHK) -> no reg_wr; tx sends 15; err_count=1.
- CMD 07 after A5 -> immediate 15 with no further bytes consumed. Bytes 55 00 in IDLE -> no tx and no error.
- TIMEOUT_CYCLES=50: send A5 01, then idle 60 cycles -> state IDLE, err_count incremented, no tx. Hold tx_ready low 20 cycles during a read response -> tx_data stable, no bytes lost.
- Force err_count=255 with ERRCNT_WIDTH=8, then send a bad CHK -> stays 255. Assert rstb_cac low mid-TX_DATA -> all outputs 0 immediately; next valid frame is processed normally.
